// File: rtl/serial_rx_pkg.sv
// Shared state type, parity-mode constants and parity helper for the serial frame receiver.
package serial_rx_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Expected parity bit; zero-extending the word does not change its parity.
    function automatic logic parity_bit(input logic [15:0] data, input int unsigned mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/serial_rx_buffered_if.sv
// Read-side ready/valid port of the buffered serial receiver.
interface serial_rx_buffered_if #(
    parameter int unsigned DATA_W     = 7,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CountW = $clog2(FIFO_DEPTH) + 1;

    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_parity_err;
    logic [CountW-1:0] fifo_count;

    modport master (
        output rd_valid,
        output rd_data,
        output rd_parity_err,
        output fifo_count,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        input  rd_parity_err,
        input  fifo_count,
        output rd_ready
    );
endinterface

// File: rtl/rx_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO succeeds only alongside a pop.
module rx_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PtrW + 1)'(DEPTH));
    assign do_pop  = rd_en && !empty;
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/serial_rx_buffered.sv
// Serial frame receiver (start 1, data LSB first, optional parity, stop bits of 1)
// feeding a tagged show-ahead receive FIFO.
module serial_rx_buffered
    import serial_rx_pkg::*;
#(
    parameter int unsigned DATA_W       = 7,
    parameter int unsigned PARITY_MODE  = 1,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 channel_in,
    serial_rx_buffered_if.master rd,
    output logic                 frame_err,
    output logic                 overflow,
    input  logic                 clr_overflow
);
    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] HalfLoad =
        CntW'((CLKS_PER_BIT > 1) ? (CLKS_PER_BIT / 2 - 1) : 0);
    localparam logic [CntW-1:0] FullLoad = CntW'(CLKS_PER_BIT - 1);
    localparam logic [4:0] LastData = 5'(DATA_W - 1);
    localparam logic [4:0] LastStop = 5'(STOP_BITS - 1);

    rx_state_t         state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [4:0]        bit_q, bit_d;
    logic [DATA_W-1:0] sr_q, sr_d;
    logic              perr_q, perr_d;
    logic              push_q, push_d;
    logic              frame_err_q, frame_err_d;
    logic              overflow_q, overflow_d;
    logic              tick;

    logic [DATA_W:0]   head;
    logic              fifo_full, fifo_empty, ov_set;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sr_d        = sr_q;
        perr_d      = perr_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        tick        = (cnt_q == '0);

        unique case (state_q)
            IDLE: begin
                if (channel_in) begin
                    bit_d  = '0;
                    perr_d = 1'b0;
                    // With one clock per bit there is no mid-bit point to re-check.
                    if (CLKS_PER_BIT > 1) begin
                        state_d = START;
                        cnt_d   = HalfLoad;
                    end else begin
                        state_d = DATA;
                        cnt_d   = FullLoad;
                    end
                end
            end
            START: begin
                if (tick) begin
                    cnt_d   = FullLoad;
                    state_d = channel_in ? DATA : IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    cnt_d = FullLoad;
                    for (int i = 0; i < int'(DATA_W) - 1; i++) sr_d[i] = sr_q[i+1];
                    sr_d[DATA_W-1] = channel_in;
                    if (bit_q == LastData) begin
                        bit_d   = '0;
                        state_d = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PARITY: begin
                if (tick) begin
                    cnt_d   = FullLoad;
                    perr_d  = (channel_in != parity_bit(16'(sr_q), PARITY_MODE));
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    cnt_d = FullLoad;
                    if (!channel_in) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else if (bit_q == LastStop) begin
                        push_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sr_q        <= '0;
            perr_q      <= 1'b0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sr_q        <= sr_d;
            perr_q      <= perr_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overflow_q  <= overflow_d;
        end
    end

    // A same-cycle pop frees a slot, so only a push with no pop against a full FIFO drops.
    assign ov_set = push_q && fifo_full && !(rd.rd_ready && !fifo_empty);

    always_comb begin
        overflow_d = overflow_q;
        if (ov_set) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end
    end

    rx_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (push_q),
        .wr_data ({perr_q, sr_q}),
        .rd_en   (rd.rd_ready),
        .rd_data (head),
        .count   (rd.fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rd.rd_valid      = !fifo_empty;
    assign rd.rd_data       = head[DATA_W-1:0];
    assign rd.rd_parity_err = head[DATA_W];
    assign frame_err        = frame_err_q;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_serial_rx_buffered.sv
// Bench for serial_rx_buffered: a one-clock-per-bit even-parity receiver and an
// eight-clock-per-bit odd-parity receiver, checked against a frame-level queue model.
module tb_serial_rx_buffered;
    localparam int unsigned W     = 7;
    localparam int unsigned DEPTH = 4;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic ch_a = 1'b0, ch_b = 1'b0;
    logic clr_a = 1'b0, clr_b = 1'b0;
    logic fe_a, fe_b, ov_a, ov_b;
    int   checks = 0, errors = 0;
    int   fe_hi_a = 0, fe_hi_b = 0;

    serial_rx_buffered_if #(.DATA_W(W), .FIFO_DEPTH(DEPTH)) if_a ();
    serial_rx_buffered_if #(.DATA_W(W), .FIFO_DEPTH(DEPTH)) if_b ();

    serial_rx_buffered #(
        .DATA_W(W), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(1), .FIFO_DEPTH(DEPTH)
    ) dut_a (
        .clk(clk), .rstn(rstn), .channel_in(ch_a), .rd(if_a),
        .frame_err(fe_a), .overflow(ov_a), .clr_overflow(clr_a)
    );

    serial_rx_buffered #(
        .DATA_W(W), .PARITY_MODE(2), .STOP_BITS(1), .CLKS_PER_BIT(8), .FIFO_DEPTH(DEPTH)
    ) dut_b (
        .clk(clk), .rstn(rstn), .channel_in(ch_b), .rd(if_b),
        .frame_err(fe_b), .overflow(ov_b), .clr_overflow(clr_b)
    );

    always #5 clk = ~clk;

    // Count cycles in which frame_err is high, to measure pulse widths.
    always @(negedge clk) begin
        if (fe_a) fe_hi_a <= fe_hi_a + 1;
        if (fe_b) fe_hi_b <= fe_hi_b + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached before the bench completed");
        $fatal(1);
    end

    // Line order: start 1, data LSB first, parity, stop.
    function automatic logic [9:0] frame_bits(input logic [6:0] d, input logic p, input logic s);
        return {s, p, d, 1'b1};
    endfunction

    task automatic drive_a(input logic b);
        @(negedge clk);
        ch_a = b;
        #1;
    endtask

    task automatic send_a(input logic [6:0] d, input logic p, input logic s);
        logic [9:0] fr;
        fr = frame_bits(d, p, s);
        for (int i = 0; i < 10; i++) drive_a(fr[i]);
    endtask

    task automatic send_b(input logic [6:0] d, input logic p, input logic s);
        logic [9:0] fr;
        fr = frame_bits(d, p, s);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ch_b = fr[i];
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        ch_b = 1'b0;
        repeat (16) @(negedge clk);
        #1;
    endtask

    task automatic pop_a(output logic [6:0] d, output logic pe, output logic v);
        @(negedge clk);
        v  = if_a.rd_valid;
        d  = if_a.rd_data;
        pe = if_a.rd_parity_err;
        if_a.rd_ready = 1'b1;
        @(negedge clk);
        if_a.rd_ready = 1'b0;
        #1;
    endtask

    task automatic pop_b();
        @(negedge clk);
        if_b.rd_ready = 1'b1;
        @(negedge clk);
        if_b.rd_ready = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [13:0] obs;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        obs = {if_a.rd_valid, if_a.rd_data, if_a.rd_parity_err, if_a.fifo_count, fe_a, ov_a};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_a: outputs %b, required all 0", obs);
        end
        obs = {if_b.rd_valid, if_b.rd_data, if_b.rd_parity_err, if_b.fifo_count, fe_b, ov_b};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_b: outputs %b, required all 0", obs);
        end
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [6:0] d;
        logic       pe, v;
        send_a(7'h5A, ^(7'h5A), 1'b1);
        drive_a(1'b0);
        checks++;
        if (if_a.fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL push_early: count %0d before edge 10, required 0", if_a.fifo_count);
        end
        drive_a(1'b0);
        checks++;
        if ({if_a.rd_valid, if_a.fifo_count, if_a.rd_parity_err, if_a.rd_data} !==
            {1'b1, 3'd1, 1'b0, 7'h5A}) begin
            errors++;
            $display("FAIL basic_5a: valid %b count %0d perr %b data %h, required 1 1 0 5a",
                     if_a.rd_valid, if_a.fifo_count, if_a.rd_parity_err, if_a.rd_data);
        end
        pop_a(d, pe, v);
        pop_a(d, pe, v);
        checks++;
        if ({v, if_a.fifo_count, if_a.rd_data, if_a.rd_parity_err} !== '0) begin
            errors++;
            $display("FAIL empty_pop: valid %b count %0d data %h perr %b, required all 0",
                     v, if_a.fifo_count, if_a.rd_data, if_a.rd_parity_err);
        end
    endtask

    task automatic test_parity();
        logic [6:0] d, rd;
        logic       p, pe, v;
        send_a(7'h5A, 1'b1, 1'b1);
        drive_a(1'b0);
        drive_a(1'b0);
        pop_a(rd, pe, v);
        checks++;
        if ({v, pe, rd} !== {1'b1, 1'b1, 7'h5A}) begin
            errors++;
            $display("FAIL parity_bad_even: valid %b perr %b data %h, required 1 1 5a", v, pe, rd);
        end
        for (int i = 0; i < 8; i++) begin
            d = 7'($urandom);
            p = 1'($urandom);
            send_a(d, p, 1'b1);
            drive_a(1'b0);
            drive_a(1'b0);
            pop_a(rd, pe, v);
            checks++;
            if ({v, pe, rd} !== {1'b1, (p != ^d), d}) begin
                errors++;
                $display("FAIL parity_rand_%0d: valid %b perr %b data %h, required 1 %b %h",
                         i, v, pe, rd, (p != ^d), d);
            end
        end
        send_b(7'h5A, 1'b1, 1'b1);
        checks++;
        if ({if_b.fifo_count, if_b.rd_parity_err, if_b.rd_data} !== {3'd1, 1'b0, 7'h5A}) begin
            errors++;
            $display("FAIL parity_odd_b: count %0d perr %b data %h, required 1 0 5a",
                     if_b.fifo_count, if_b.rd_parity_err, if_b.rd_data);
        end
        pop_b();
    endtask

    task automatic test_frame_err();
        int         base;
        logic [6:0] rd;
        logic       pe, v;
        base = fe_hi_a;
        send_a(7'h5A, 1'b0, 1'b0);
        drive_a(1'b0);
        checks++;
        if (fe_a !== 1'b1) begin
            errors++;
            $display("FAIL frame_err_pulse: frame_err %b after bad stop, required 1", fe_a);
        end
        drive_a(1'b0);
        drive_a(1'b0);
        checks++;
        if ({fe_hi_a - base, 32'(if_a.fifo_count)} !== {32'd1, 32'd0}) begin
            errors++;
            $display("FAIL frame_err_width: high cycles %0d count %0d, required 1 0",
                     fe_hi_a - base, if_a.fifo_count);
        end
        send_a(7'h11, ^(7'h11), 1'b1);
        drive_a(1'b0);
        drive_a(1'b0);
        pop_a(rd, pe, v);
        checks++;
        if ({v, pe, rd} !== {1'b1, 1'b0, 7'h11}) begin
            errors++;
            $display("FAIL after_frame_err: valid %b perr %b data %h, required 1 0 11", v, pe, rd);
        end
    endtask

    task automatic test_overflow();
        logic [6:0] rd, k;
        logic       pe, v;
        if_a.rd_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            k = 7'(i);
            send_a(k, ^k, 1'b1);
            drive_a(1'b0);
            drive_a(1'b0);
        end
        checks++;
        if ({if_a.fifo_count, ov_a} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL fill_4: count %0d overflow %b, required 4 0", if_a.fifo_count, ov_a);
        end
        // Clear held across the dropping push: the set must win.
        clr_a = 1'b1;
        send_a(7'h05, ^(7'h05), 1'b1);
        drive_a(1'b0);
        drive_a(1'b0);
        clr_a = 1'b0;
        checks++;
        if ({if_a.fifo_count, ov_a, if_a.rd_data} !== {3'd4, 1'b1, 7'h01}) begin
            errors++;
            $display("FAIL overflow_set: count %0d overflow %b head %h, required 4 1 01",
                     if_a.fifo_count, ov_a, if_a.rd_data);
        end
        for (int i = 1; i <= 4; i++) begin
            pop_a(rd, pe, v);
            checks++;
            if ({v, rd} !== {1'b1, 7'(i)}) begin
                errors++;
                $display("FAIL overflow_order_%0d: valid %b data %h, required 1 %h", i, v, rd,
                         7'(i));
            end
        end
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        #1;
        checks++;
        if ({ov_a, if_a.fifo_count} !== {1'b0, 3'd0}) begin
            errors++;
            $display("FAIL overflow_clear: overflow %b count %0d, required 0 0", ov_a,
                     if_a.fifo_count);
        end
    endtask

    task automatic test_back_to_back();
        logic       bits[$];
        logic [7:0] got[$];
        logic [9:0] f0, f1;
        f0 = frame_bits(7'h33, ^(7'h33), 1'b1);
        f1 = frame_bits(7'h4C, ^(7'h4C), 1'b1);
        for (int i = 0; i < 10; i++) bits.push_back(f0[i]);
        for (int i = 0; i < 10; i++) bits.push_back(f1[i]);
        repeat (14) bits.push_back(1'b0);
        for (int j = 0; j < bits.size(); j++) begin
            @(negedge clk);
            ch_a = bits[j];
            if_a.rd_ready = ((j % 2) == 1);
            #1;
            if (if_a.rd_valid && if_a.rd_ready) got.push_back({if_a.rd_parity_err, if_a.rd_data});
        end
        if_a.rd_ready = 1'b0;
        checks++;
        if (got.size() != 2) begin
            errors++;
            $display("FAIL b2b_count: %0d words popped, required 2", got.size());
        end else begin
            checks++;
            if ({got[0], got[1]} !== {8'h33, 8'h4C}) begin
                errors++;
                $display("FAIL b2b_order: popped %h %h, required 33 4c", got[0], got[1]);
            end
        end
    endtask

    task automatic test_random();
        bit         push_at[512];
        logic [7:0] word_at[512];
        bit         fe_at[512];
        logic       stream[$];
        logic [7:0] mq[$];
        logic [7:0] exp_head;
        logic [9:0] fr;
        logic [6:0] d;
        logic       p, s, mov, rdy, pop;
        int         k;
        for (int i = 0; i < 512; i++) begin
            push_at[i] = 1'b0;
            fe_at[i]   = 1'b0;
            word_at[i] = '0;
        end
        for (int f = 0; f < 14; f++) begin
            d  = 7'($urandom);
            p  = 1'($urandom);
            s  = ($urandom_range(5) != 0);
            fr = frame_bits(d, p, s);
            k  = stream.size();
            for (int b = 0; b < 10; b++) stream.push_back(fr[b]);
            // Bit j of the stream is sampled at edge j; push lands one edge after the stop.
            if (s) begin
                push_at[k+10] = 1'b1;
                word_at[k+10] = {(p != ^d), d};
            end else begin
                fe_at[k+9] = 1'b1;
            end
            repeat ($urandom_range(3)) stream.push_back(1'b0);
        end
        repeat (16) stream.push_back(1'b0);
        mov = 1'b0;
        for (int j = 0; j < stream.size(); j++) begin
            rdy = ($urandom_range(9) < 3);
            @(negedge clk);
            ch_a = stream[j];
            if_a.rd_ready = rdy;
            #1;
            exp_head = (mq.size() != 0) ? mq[0] : 8'h00;
            checks++;
            if (if_a.rd_valid !== (mq.size() != 0)) begin
                errors++;
                $display("FAIL rand_valid@%0d: got %b, required %b", j, if_a.rd_valid,
                         (mq.size() != 0));
            end
            checks++;
            if ({if_a.rd_parity_err, if_a.rd_data} !== exp_head) begin
                errors++;
                $display("FAIL rand_head@%0d: got %h, required %h", j,
                         {if_a.rd_parity_err, if_a.rd_data}, exp_head);
            end
            checks++;
            if (if_a.fifo_count !== 3'(mq.size())) begin
                errors++;
                $display("FAIL rand_count@%0d: got %0d, required %0d", j, if_a.fifo_count,
                         mq.size());
            end
            checks++;
            if (ov_a !== mov) begin
                errors++;
                $display("FAIL rand_overflow@%0d: got %b, required %b", j, ov_a, mov);
            end
            checks++;
            if (fe_a !== ((j > 0) && fe_at[j-1])) begin
                errors++;
                $display("FAIL rand_frame_err@%0d: got %b, required %b", j, fe_a,
                         ((j > 0) && fe_at[j-1]));
            end
            pop = rdy && (mq.size() != 0);
            if (pop) void'(mq.pop_front());
            if (push_at[j]) begin
                if ((mq.size() == DEPTH) && !pop) mov = 1'b1;
                else mq.push_back(word_at[j]);
            end
        end
        if_a.rd_ready = 1'b0;
    endtask

    task automatic test_glitch_b();
        int base;
        base = fe_hi_b;
        @(negedge clk);
        ch_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        ch_b = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if ({32'(if_b.fifo_count), fe_hi_b - base} !== {32'd0, 32'd0}) begin
            errors++;
            $display("FAIL glitch_b: count %0d frame_err cycles %0d, required 0 0",
                     if_b.fifo_count, fe_hi_b - base);
        end
        send_b(7'h7F, ~^(7'h7F), 1'b1);
        checks++;
        if ({if_b.fifo_count, if_b.rd_parity_err, if_b.rd_data} !== {3'd1, 1'b0, 7'h7F}) begin
            errors++;
            $display("FAIL frame_b_7f: count %0d perr %b data %h, required 1 0 7f",
                     if_b.fifo_count, if_b.rd_parity_err, if_b.rd_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [13:0] obs;
        int          base;
        send_a(7'h2B, ^(7'h2B), 1'b1);
        drive_a(1'b0);
        drive_a(1'b0);
        // Start bit plus three data bits on the slow receiver, then reset mid-DATA.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            ch_b = (i == 0) || (i == 2);
            repeat (7) @(negedge clk);
        end
        @(negedge clk);
        ch_b = 1'b0;
        rstn = 1'b0;
        #1;
        obs = {if_b.rd_valid, if_b.rd_data, if_b.rd_parity_err, if_b.fifo_count, fe_b, ov_b};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_mid_b: outputs %b, required all 0", obs);
        end
        obs = {if_a.rd_valid, if_a.rd_data, if_a.rd_parity_err, if_a.fifo_count, fe_a, ov_a};
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_mid_a: outputs %b, required all 0", obs);
        end
        @(negedge clk);
        rstn = 1'b1;
        base = fe_hi_b;
        repeat (100) @(negedge clk);
        #1;
        checks++;
        if ({if_b.rd_valid, if_b.fifo_count} !== '0 || fe_hi_b != base) begin
            errors++;
            $display("FAIL reset_abort_b: valid %b count %0d frame_err cycles %0d, required 0 0 0",
                     if_b.rd_valid, if_b.fifo_count, fe_hi_b - base);
        end
    endtask

    initial begin
        if_a.rd_ready = 1'b0;
        if_b.rd_ready = 1'b0;
        test_reset();
        test_basic();
        test_parity();
        test_frame_err();
        test_overflow();
        test_back_to_back();
        test_random();
        test_glitch_b();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
